// File: rtl/dec_deformatter_pkg.sv
// rtl/dec_deformatter_pkg.sv - shared code geometry and symbol type for the deformatter
package dec_deformatter_pkg;

    localparam int EGF_ORDER   = 8;
    localparam int ENC_SYM_NUM = 16;
    localparam int RS_COD_LEN  = 255;
    localparam int RS_MES_LEN  = 223;

    localparam int POS_W  = $clog2(RS_COD_LEN);
    localparam int CNT_W  = $clog2(ENC_SYM_NUM + 1);
    localparam int IDX_W  = $clog2(ENC_SYM_NUM);
    localparam int BEAT_W = ENC_SYM_NUM * EGF_ORDER;

    typedef logic [EGF_ORDER-1:0] sym_t;

endpackage

// File: rtl/dec_compactor.sv
// rtl/dec_compactor.sv - classifies beat lanes as message/parity and packs message lanes to the bottom
module dec_compactor
    import dec_deformatter_pkg::*;
(
    input  logic [POS_W-1:0]  dec_pos,
    input  logic [BEAT_W-1:0] in_data,
    output logic [BEAT_W-1:0] cmp_data,
    output logic [CNT_W-1:0]  msg_cnt,
    output logic              last_hit,
    output logic [IDX_W-1:0]  last_idx
);

    localparam logic [POS_W:0] COD_P  = (POS_W+1)'(RS_COD_LEN);
    localparam logic [POS_W:0] MES_P  = (POS_W+1)'(RS_MES_LEN);
    localparam logic [POS_W:0] LAST_P = (POS_W+1)'(RS_MES_LEN - 1);

    sym_t           in_sym  [ENC_SYM_NUM];
    sym_t           cmp_sym [ENC_SYM_NUM];
    logic [POS_W:0] pos;

    for (genvar g = 0; g < ENC_SYM_NUM; g++) begin : g_lane
        assign in_sym[g] = in_data[g*EGF_ORDER +: EGF_ORDER];
        assign cmp_data[g*EGF_ORDER +: EGF_ORDER] = cmp_sym[g];
    end

    // A beat never spans more than one codeword boundary, so one conditional subtract wraps.
    always_comb begin
        msg_cnt  = '0;
        last_hit = 1'b0;
        last_idx = '0;
        pos      = '0;
        for (int i = 0; i < ENC_SYM_NUM; i++) begin
            cmp_sym[i] = '0;
        end
        for (int i = 0; i < ENC_SYM_NUM; i++) begin
            pos = {1'b0, dec_pos} + (POS_W+1)'(i);
            if (pos >= COD_P) begin
                pos = pos - COD_P;
            end
            if (pos < MES_P) begin
                if (pos == LAST_P) begin
                    last_hit = 1'b1;
                    last_idx = msg_cnt[IDX_W-1:0];
                end
                cmp_sym[msg_cnt[IDX_W-1:0]] = in_sym[i];
                msg_cnt = msg_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dec_deformatter.sv
// rtl/dec_deformatter.sv - strips RS parity and repacks message symbols into dense beats; DEC_DEFORMATTER_FLUSH_EN adds flush/out_count
module dec_deformatter
    import dec_deformatter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_last,
    output logic [POS_W-1:0]  dec_pos
`ifdef DEC_DEFORMATTER_FLUSH_EN
    ,
    input  logic              flush,
    output logic [CNT_W-1:0]  out_count
`endif
);

    localparam logic [CNT_W:0] FULL  = (CNT_W+1)'(ENC_SYM_NUM);
    localparam logic [POS_W:0] COD_P = (POS_W+1)'(RS_COD_LEN);

    logic [BEAT_W-1:0]   res_data;
    logic [CNT_W-1:0]    res_cnt;
    logic                res_last;

    logic [BEAT_W-1:0]   cmp_data;
    logic [CNT_W-1:0]    msg_cnt;
    logic                last_hit;
    logic [IDX_W-1:0]    last_idx;

    logic [31:0]         shamt;
    logic [2*BEAT_W-1:0] win;
    logic [CNT_W:0]      total;
    logic [CNT_W:0]      last_pos;
    logic                emit;
    logic                last_in_out;
    logic                out_free;
    logic                accept;
    logic [POS_W:0]      pos_sum;
    logic [POS_W:0]      pos_wrap;
    logic [POS_W-1:0]    pos_next;

    dec_compactor u_compactor (
        .dec_pos  (dec_pos),
        .in_data  (in_data),
        .cmp_data (cmp_data),
        .msg_cnt  (msg_cnt),
        .last_hit (last_hit),
        .last_idx (last_idx)
    );

    assign out_free = !out_valid || out_ready;
`ifdef DEC_DEFORMATTER_FLUSH_EN
    assign in_ready = out_free && !flush;
`else
    assign in_ready = out_free;
`endif
    assign accept = in_valid && in_ready;

    // Residual lanes above res_cnt are kept zero so the window is a plain OR.
    assign shamt       = 32'(res_cnt) * 32'(EGF_ORDER);
    assign win         = ({{BEAT_W{1'b0}}, cmp_data} << shamt) | {{BEAT_W{1'b0}}, res_data};
    assign total       = {1'b0, res_cnt} + {1'b0, msg_cnt};
    assign emit        = total >= FULL;
    assign last_pos    = {1'b0, res_cnt} + {{(CNT_W-IDX_W+1){1'b0}}, last_idx};
    assign last_in_out = last_hit && (last_pos < FULL);

    assign pos_sum  = {1'b0, dec_pos} + (POS_W+1)'(ENC_SYM_NUM);
    assign pos_wrap = pos_sum - COD_P;
    assign pos_next = (pos_sum >= COD_P) ? pos_wrap[POS_W-1:0] : pos_sum[POS_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            dec_pos   <= '0;
            res_data  <= '0;
            res_cnt   <= '0;
            res_last  <= 1'b0;
`ifdef DEC_DEFORMATTER_FLUSH_EN
            out_count <= '0;
`endif
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef DEC_DEFORMATTER_FLUSH_EN
            if (flush && out_free) begin
                dec_pos  <= '0;
                res_data <= '0;
                res_cnt  <= '0;
                res_last <= 1'b0;
                if (res_cnt != '0) begin
                    out_valid <= 1'b1;
                    out_data  <= res_data;
                    out_last  <= res_last;
                    out_count <= res_cnt;
                end
            end else
`endif
            if (accept) begin
                dec_pos <= pos_next;
                if (emit) begin
                    out_valid <= 1'b1;
                    out_data  <= win[BEAT_W-1:0];
                    out_last  <= res_last || last_in_out;
                    res_data  <= win[2*BEAT_W-1:BEAT_W];
                    res_cnt   <= total[CNT_W-1:0] - CNT_W'(ENC_SYM_NUM);
                    res_last  <= last_hit && !last_in_out;
`ifdef DEC_DEFORMATTER_FLUSH_EN
                    out_count <= CNT_W'(ENC_SYM_NUM);
`endif
                end else begin
                    res_data <= win[BEAT_W-1:0];
                    res_cnt  <= total[CNT_W-1:0];
                    res_last <= res_last || last_hit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (res_cnt < CNT_W'(ENC_SYM_NUM));
        end
    end

endmodule

// File: tb/tb_dec_deformatter.sv
// tb/tb_dec_deformatter.sv - directed self-checking bench for dec_deformatter
module tb_dec_deformatter;
    import dec_deformatter_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BEAT_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [BEAT_W-1:0] out_data;
    logic              out_last;
    logic [POS_W-1:0]  dec_pos;
`ifdef DEC_DEFORMATTER_FLUSH_EN
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  out_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    bit rnd_en = 1'b0;

    logic [BEAT_W-1:0] got_data [$];
    logic              got_last [$];

    always #5 clk = ~clk;

    dec_deformatter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .dec_pos   (dec_pos)
`ifdef DEC_DEFORMATTER_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time expired, want completion");
        $fatal(1);
    end

    function automatic logic [BEAT_W-1:0] stream_beat(input int s);
        logic [BEAT_W-1:0] b;
        for (int l = 0; l < ENC_SYM_NUM; l++) begin
            b[l*EGF_ORDER +: EGF_ORDER] = EGF_ORDER'((s + l) % 256);
        end
        return b;
    endfunction

    function automatic logic [BEAT_W-1:0] exp_beat(input int base, input int b);
        logic [BEAT_W-1:0] r;
        int m;
        for (int l = 0; l < ENC_SYM_NUM; l++) begin
            m = b * ENC_SYM_NUM + l;
            r[l*EGF_ORDER +: EGF_ORDER] =
                EGF_ORDER'((base + (m / RS_MES_LEN) * RS_COD_LEN + (m % RS_MES_LEN)) % 256);
        end
        return r;
    endfunction

    function automatic logic exp_last(input int b);
        logic r;
        r = 1'b0;
        for (int l = 0; l < ENC_SYM_NUM; l++) begin
            if (((b * ENC_SYM_NUM + l) % RS_MES_LEN) == RS_MES_LEN - 1) r = 1'b1;
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
`ifdef DEC_DEFORMATTER_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_data.delete();
        got_last.delete();
    endtask

    task automatic drive_beat(input int s);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = stream_beat(s);
        @(negedge clk);
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL drive_timeout: in_ready=0 for symbol %0d, want 1", s);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = stream_beat(7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        n_cmp++; if (dec_pos !== '0) begin n_fail++; $display("FAIL rst_dec_pos: got %0d want 0", dec_pos); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [BEAT_W-1:0] want;
        logic              want_v;
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            drive_beat(16 * b);
            want_v = (b <= 12) || (b == 15);
            n_cmp++;
            if (out_valid !== want_v) begin n_fail++; $display("FAIL stream_valid beat %0d: got %b want %b", b, out_valid, want_v); end
            if (want_v) begin
                if (b == 15) begin
                    for (int l = 0; l < 15; l++) want[l*EGF_ORDER +: EGF_ORDER] = EGF_ORDER'(208 + l);
                    want[15*EGF_ORDER +: EGF_ORDER] = 8'hFF;
                end else begin
                    want = stream_beat(16 * b);
                end
                n_cmp++;
                if (out_data !== want) begin n_fail++; $display("FAIL stream_data beat %0d: got %h want %h", b, out_data, want); end
                n_cmp++;
                if (out_last !== (b == 15)) begin n_fail++; $display("FAIL stream_last beat %0d: got %b want %b", b, out_last, b == 15); end
`ifdef DEC_DEFORMATTER_FLUSH_EN
                n_cmp++;
                if (out_count !== CNT_W'(16)) begin n_fail++; $display("FAIL stream_count beat %0d: got %0d want 16", b, out_count); end
`endif
            end
        end
        n_cmp++; if (dec_pos !== POS_W'(1)) begin n_fail++; $display("FAIL stream_dec_pos: got %0d want 1", dec_pos); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 4; b++) drive_beat(16 * b);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = stream_beat(64);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_data !== stream_beat(48)) begin
                n_fail++; $display("FAIL bp_hold cycle %0d: got v=%b %h want v=1 %h", c, out_valid, out_data, stream_beat(48));
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int b = 4; b < 16; b++) drive_beat(16 * b);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() != 14) begin n_fail++; $display("FAIL bp_count: got %0d beats want 14", got_data.size()); end
        for (int b = 0; b < got_data.size() && b < 14; b++) begin
            n_cmp++; if (got_data[b] !== exp_beat(0, b)) begin n_fail++; $display("FAIL bp_data beat %0d: got %h want %h", b, got_data[b], exp_beat(0, b)); end
            n_cmp++; if (got_last[b] !== exp_last(b)) begin n_fail++; $display("FAIL bp_last beat %0d: got %b want %b", b, got_last[b], exp_last(b)); end
        end
    endtask

    task automatic test_back_to_back();
        int want_lasts;
        int seen_lasts;
        do_reset();
        rnd_en = 1'b1;
        for (int b = 0; b < 319; b++) drive_beat(16 * b);
        rnd_en = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() != 279) begin n_fail++; $display("FAIL b2b_count: got %0d beats want 279", got_data.size()); end
        want_lasts = 0;
        seen_lasts = 0;
        for (int b = 0; b < got_data.size() && b < 279; b++) begin
            if (exp_last(b)) want_lasts++;
            if (got_last[b]) seen_lasts++;
            n_cmp++; if (got_data[b] !== exp_beat(0, b)) begin n_fail++; $display("FAIL b2b_data beat %0d: got %h want %h", b, got_data[b], exp_beat(0, b)); end
            n_cmp++; if (got_last[b] !== exp_last(b)) begin n_fail++; $display("FAIL b2b_last beat %0d: got %b want %b", b, got_last[b], exp_last(b)); end
        end
        n_cmp++; if (seen_lasts != want_lasts) begin n_fail++; $display("FAIL b2b_last_total: got %0d want %0d", seen_lasts, want_lasts); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 8; b++) drive_beat(16 * b);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL mid_data: got %h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL mid_last: got %b want 0", out_last); end
        n_cmp++; if (dec_pos !== '0) begin n_fail++; $display("FAIL mid_dec_pos: got %0d want 0", dec_pos); end
        rst = 1'b0;
        got_data.delete();
        got_last.delete();
        for (int b = 0; b < 14; b++) drive_beat(1000 + 16 * b);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() != 13) begin n_fail++; $display("FAIL mid_count: got %0d beats want 13", got_data.size()); end
        for (int b = 0; b < got_data.size() && b < 13; b++) begin
            n_cmp++; if (got_data[b] !== exp_beat(1000, b)) begin n_fail++; $display("FAIL mid_data beat %0d: got %h want %h", b, got_data[b], exp_beat(1000, b)); end
            n_cmp++; if (got_last[b] !== 1'b0) begin n_fail++; $display("FAIL mid_last beat %0d: got %b want 0", b, got_last[b]); end
        end
        n_cmp++; if (dec_pos !== POS_W'(224)) begin n_fail++; $display("FAIL mid_dec_pos_end: got %0d want 224", dec_pos); end
    endtask

`ifdef DEC_DEFORMATTER_FLUSH_EN
    task automatic test_flush_partial();
        logic [BEAT_W-1:0] want;
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 14; b++) drive_beat(16 * b);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        want = '0;
        for (int l = 0; l < 15; l++) want[l*EGF_ORDER +: EGF_ORDER] = EGF_ORDER'(208 + l);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_count !== CNT_W'(15)) begin n_fail++; $display("FAIL flush_count: got %0d want 15", out_count); end
        n_cmp++; if (out_data !== want) begin n_fail++; $display("FAIL flush_data: got %h want %h", out_data, want); end
        n_cmp++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL flush_last: got %b want 1", out_last); end
        n_cmp++; if (dec_pos !== '0) begin n_fail++; $display("FAIL flush_dec_pos: got %0d want 0", dec_pos); end
    endtask

    task automatic test_flush_empty();
        do_reset();
        out_ready = 1'b1;
        drive_beat(0);
        n_cmp++; if (dec_pos !== POS_W'(16)) begin n_fail++; $display("FAIL flush0_pre_pos: got %0d want 16", dec_pos); end
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = stream_beat(16);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush0_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush0_valid: got %b want 0", out_valid); end
        n_cmp++; if (dec_pos !== '0) begin n_fail++; $display("FAIL flush0_dec_pos: got %0d want 0", dec_pos); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef DEC_DEFORMATTER_FLUSH_EN
        test_flush_partial();
        test_flush_empty();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
